// File: rtl/triangle_cmd_decoder.sv
// triangle_cmd_decoder
// Reads two-word commands from a first-word-fall-through FIFO. Triangles go
// to the rasterizer, EFB/EF commands become flush and frame-end requests.
// Delivered triangles, flushes and frames are counted, and an illegal opcode
// raises a sticky flag.
module triangle_cmd_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [239:0]     fifo_rddata,
  output logic             fifo_pop,
  output logic [479:0]     tri_data,
  output logic             tri_valid,
  input  logic             tri_ready,
  output logic             efb_req,
  input  logic             efb_ack,
  output logic             ef_req,
  input  logic             ef_ack,
  output logic             draw_next,
  output logic [CNT_W-1:0] tri_count,
  output logic [CNT_W-1:0] efb_count,
  output logic [CNT_W-1:0] frame_count,
  output logic             proto_err
);

  typedef enum logic [2:0] {
    FETCH1,
    FETCH2,
    TRI,
    EFB,
    EF
  } state_t;

  typedef enum logic [1:0] {
    OP_TRI = 2'b00,
    OP_EF  = 2'b01,
    OP_EFB = 2'b10,
    OP_ILL = 2'b11
  } opcode_t;

  state_t       state;
  logic [239:0] word1;
  logic [239:0] word2;
  // High for the first cycle after rst falls, so the FIFO is left untouched
  // both during reset and on the cycle that follows it.
  logic         rst_q;
  opcode_t      opcode;

  assign opcode   = opcode_t'(word1[7:6]);
  assign tri_data = {word1, word2};

  // NOTE: fifo_pop is left combinational on purpose. The FIFO drops its head
  // word on the same edge where the word is captured, so registering the pop
  // would consume each word one cycle late and read it twice.
  assign fifo_pop = !rst && !rst_q && !fifo_empty &&
                    ((state == FETCH1) || (state == FETCH2));

  // Command FSM. Outputs are registered and updated together with the state.
  always_ff @(posedge clk) begin
    // NOTE: every sequential assignment is non-blocking, so all flops update
    // on the same edge no matter the order of statements in this block.
    if (rst) begin
      state       <= FETCH1;
      word1       <= '0;
      word2       <= '0;
      rst_q       <= 1'b1;
      tri_valid   <= 1'b0;
      efb_req     <= 1'b0;
      ef_req      <= 1'b0;
      draw_next   <= 1'b0;
      tri_count   <= '0;
      efb_count   <= '0;
      frame_count <= '0;
      proto_err   <= 1'b0;
    end else begin
      rst_q     <= 1'b0;
      draw_next <= 1'b0;
      case (state)
        FETCH1: begin
          if (fifo_pop) begin
            word1 <= fifo_rddata;
            state <= FETCH2;
          end
        end
        FETCH2: begin
          if (fifo_pop) begin
            word2 <= fifo_rddata;
            case (opcode)
              OP_TRI: begin
                state     <= TRI;
                tri_valid <= 1'b1;
              end
              OP_EFB: begin
                state   <= EFB;
                efb_req <= 1'b1;
              end
              OP_EF: begin
                state  <= EF;
                ef_req <= 1'b1;
              end
              default: begin
                proto_err <= 1'b1;
                state     <= FETCH1;
              end
            endcase
          end
        end
        TRI: begin
          if (tri_ready) begin
            state     <= FETCH1;
            tri_valid <= 1'b0;
            tri_count <= tri_count + CNT_W'(1);
          end
        end
        EFB: begin
          if (efb_ack) begin
            state     <= FETCH1;
            efb_req   <= 1'b0;
            efb_count <= efb_count + CNT_W'(1);
            draw_next <= 1'b1;
          end
        end
        EF: begin
          if (ef_ack) begin
            state       <= FETCH1;
            ef_req      <= 1'b0;
            frame_count <= frame_count + CNT_W'(1);
            draw_next   <= 1'b1;
          end
        end
        default: begin
          state     <= FETCH1;
          tri_valid <= 1'b0;
          efb_req   <= 1'b0;
          ef_req    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_triangle_cmd_decoder.sv
// tb_triangle_cmd_decoder
// Directed bench for the command decoder. Expected triangles go into a
// scoreboard queue when their words are driven and are popped when tri_valid
// shows up. CNT_W is reduced to 2 so that counter wrap is reached quickly.
module tb_triangle_cmd_decoder;

  localparam int CNT_W = 2;

  logic             clk;
  logic             rst;
  logic             fifo_empty;
  logic [239:0]     fifo_rddata;
  logic             fifo_pop;
  logic [479:0]     tri_data;
  logic             tri_valid;
  logic             tri_ready;
  logic             efb_req;
  logic             efb_ack;
  logic             ef_req;
  logic             ef_ack;
  logic             draw_next;
  logic [CNT_W-1:0] tri_count;
  logic [CNT_W-1:0] efb_count;
  logic [CNT_W-1:0] frame_count;
  logic             proto_err;

  int n_assert = 0;
  int n_fail   = 0;

  logic [479:0] sb[$];

  triangle_cmd_decoder #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rddata(fifo_rddata),
    .fifo_pop   (fifo_pop),
    .tri_data   (tri_data),
    .tri_valid  (tri_valid),
    .tri_ready  (tri_ready),
    .efb_req    (efb_req),
    .efb_ack    (efb_ack),
    .ef_req     (ef_req),
    .ef_ack     (ef_ack),
    .draw_next  (draw_next),
    .tri_count  (tri_count),
    .efb_count  (efb_count),
    .frame_count(frame_count),
    .proto_err  (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [479:0] obs, input logic [479:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Build a command word: 29 repeats of a seed byte over a chosen low byte.
  function automatic logic [239:0] mk(input logic [7:0] seed, input logic [7:0] low);
    return {{29{seed}}, low};
  endfunction

  // Present one word at the FIFO head, expect it to be popped this cycle.
  task automatic send_word(input string tag, input logic [239:0] w);
    fifo_empty  = 1'b0;
    fifo_rddata = w;
    #1;
    check(tag, fifo_pop, 1'b1);
    @(posedge clk);
    #1;
    fifo_empty = 1'b1;
  endtask

  // Compare the presented triangle with the oldest scoreboard entry.
  task automatic expect_tri(input string tag);
    check({tag, "_valid"}, tri_valid, 1'b1);
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s: observed triangle with empty scoreboard", tag);
    end else begin
      check({tag, "_data"}, tri_data, sb.pop_front());
    end
  endtask

  initial begin
    logic [239:0] w1;
    logic [239:0] w2;

    rst         = 1'b1;
    fifo_empty  = 1'b0;
    fifo_rddata = mk(8'h5A, 8'h00);
    tri_ready   = 1'b0;
    efb_ack     = 1'b0;
    ef_ack      = 1'b0;

    // Reset held with a non-empty FIFO.
    repeat (3) tick();
    check("rst_pop", fifo_pop, 1'b0);
    check("rst_tri_valid", tri_valid, 1'b0);
    check("rst_efb_req", efb_req, 1'b0);
    check("rst_ef_req", ef_req, 1'b0);
    check("rst_draw_next", draw_next, 1'b0);
    check("rst_proto_err", proto_err, 1'b0);
    check("rst_counts", {tri_count, efb_count, frame_count}, '0);
    check("rst_tri_data", tri_data, '0);

    // Cycle right after reset: still no pop.
    rst = 1'b0;
    #1;
    check("post_rst_pop", fifo_pop, 1'b0);
    check("post_rst_tri_valid", tri_valid, 1'b0);
    fifo_empty = 1'b1;
    tick();

    // Basic triangle with tri_ready high.
    tri_ready = 1'b1;
    w1 = mk(8'h11, 8'h00);
    w2 = mk(8'h22, 8'h37);
    sb.push_back({w1, w2});
    send_word("t1_pop1", w1);
    send_word("t1_pop2", w2);
    expect_tri("t1");
    check("t1_excl", {efb_req, ef_req}, 2'b00);
    tick();
    check("t1_done", tri_valid, 1'b0);
    check("t1_count", tri_count, 2'd1);

    // Rasterizer back-pressure for 5 cycles with the FIFO non-empty.
    tri_ready = 1'b0;
    w1 = mk(8'h33, 8'h00);
    w2 = mk(8'h44, 8'hFF);
    sb.push_back({w1, w2});
    send_word("t2_pop1", w1);
    send_word("t2_pop2", w2);
    fifo_empty  = 1'b0;
    fifo_rddata = mk(8'h99, 8'h80);
    expect_tri("t2");
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t2_hold_valid", tri_valid, 1'b1);
      check("t2_hold_data", tri_data, {w1, w2});
      check("t2_hold_pop", fifo_pop, 1'b0);
      tick();
    end
    fifo_empty = 1'b1;
    tri_ready  = 1'b1;
    tick();
    check("t2_done", tri_valid, 1'b0);
    check("t2_count", tri_count, 2'd2);

    // EFB command.
    send_word("efb_pop1", mk(8'h00, 8'h80));
    send_word("efb_pop2", '0);
    for (int i = 0; i < 3; i++) begin
      check("efb_req_held", efb_req, 1'b1);
      check("efb_excl", {tri_valid, ef_req}, 2'b00);
      tick();
    end
    efb_ack = 1'b1;
    #1;
    check("efb_dn_early", draw_next, 1'b0);
    tick();
    efb_ack = 1'b0;
    check("efb_req_drop", efb_req, 1'b0);
    check("efb_dn_pulse", draw_next, 1'b1);
    check("efb_count", efb_count, 2'd1);
    tick();
    check("efb_dn_one", draw_next, 1'b0);

    // Stray acks while idle are ignored.
    efb_ack = 1'b1;
    ef_ack  = 1'b1;
    tick();
    efb_ack = 1'b0;
    ef_ack  = 1'b0;
    check("stray_counts", {efb_count, frame_count}, {2'd1, 2'd0});
    check("stray_dn", draw_next, 1'b0);

    // EF command, acked in the 10th cycle, stray efb_ack in between.
    send_word("ef_pop1", mk(8'h77, 8'h40));
    send_word("ef_pop2", mk(8'h88, 8'h12));
    for (int i = 0; i < 9; i++) begin
      efb_ack = (i == 3);
      #1;
      check("ef_req_held", ef_req, 1'b1);
      check("ef_excl", {tri_valid, efb_req}, 2'b00);
      tick();
    end
    efb_ack = 1'b0;
    check("ef_stray_efb", {efb_count, draw_next}, {2'd1, 1'b0});
    check("ef_req_10", ef_req, 1'b1);
    ef_ack = 1'b1;
    tick();
    ef_ack = 1'b0;
    check("ef_req_drop", ef_req, 1'b0);
    check("ef_frame_count", frame_count, 2'd1);
    check("ef_dn_pulse", draw_next, 1'b1);
    tick();
    check("ef_dn_one", draw_next, 1'b0);

    // Illegal opcode, then a normal triangle.
    send_word("ill_pop1", mk(8'hAB, 8'hC0));
    send_word("ill_pop2", mk(8'hCD, 8'h00));
    check("ill_err", proto_err, 1'b1);
    check("ill_no_req", {tri_valid, efb_req, ef_req}, 3'b000);
    w1 = mk(8'h3C, 8'h00);
    w2 = mk(8'hC3, 8'h01);
    sb.push_back({w1, w2});
    send_word("t3_pop1", w1);
    send_word("t3_pop2", w2);
    expect_tri("t3");
    tick();
    check("t3_count", tri_count, 2'd3);
    check("t3_err_sticky", proto_err, 1'b1);

    // Fourth triangle wraps the 2-bit counter.
    w1 = mk(8'h0F, 8'h00);
    w2 = mk(8'hF0, 8'h00);
    sb.push_back({w1, w2});
    send_word("t4_pop1", w1);
    send_word("t4_pop2", w2);
    expect_tri("t4");
    tick();
    check("t4_wrap", tri_count, 2'd0);

    // Reset after word1 of a triangle.
    send_word("rc_pop1", mk(8'hEE, 8'hC0));
    rst         = 1'b1;
    fifo_empty  = 1'b0;
    fifo_rddata = mk(8'hDD, 8'h00);
    #1;
    check("rc_pop_in_rst", fifo_pop, 1'b0);
    tick();
    tick();
    check("rc_counts", {tri_count, efb_count, frame_count}, '0);
    check("rc_err_clear", proto_err, 1'b0);
    rst = 1'b0;
    #1;
    check("rc_pop_after", fifo_pop, 1'b0);
    fifo_empty = 1'b1;
    tick();
    w1 = mk(8'h61, 8'h00);
    w2 = mk(8'h62, 8'h80);
    sb.push_back({w1, w2});
    send_word("t5_pop1", w1);
    send_word("t5_pop2", w2);
    expect_tri("t5");
    tick();
    check("t5_count", tri_count, 2'd1);
    check("t5_no_err", proto_err, 1'b0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
